fetch_unit: RTL and testbench

Instruction-fetch and program-counter stage directly upstream of the LEGv8 control unit. It holds the PC and fetches 32-bit instructions from instruction memory over a ready/request handshake. It presents the instruction register to the control unit, then updates the PC from the control word fields PS, K and the A-bus value. It also supplies the link value (PC+4) for BL and counts retired instructions.

---
 rtl/legv8_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 13 +
 rtl/pc_next_logic.sv | 30 +++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: PC-select encodings, fetch-stage state and bus widths.
package legv8_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned CNT_W   = 32;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_REG    = 2'b10;
  localparam logic [1:0] PS_BRANCH = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_e;

  // Force an address onto a 4-byte instruction boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready handshake between the fetch unit and instruction memory.
interface fetch_unit_if;
  import legv8_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: hold, sequential, register target, or PC-relative branch.
module pc_next_logic
  import legv8_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        ps,
  input  logic [ADDR_W-1:0] k,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  logic [ADDR_W-1:0] branch_off;

  assign pc_plus4   = pc + ADDR_W'(4);
  // Word offset to byte offset; the top two bits of K fall off the end.
  assign branch_off = k << 2;

  always_comb begin
    next_pc = pc;
    case (ps)
      PS_HOLD:   next_pc = pc;
      PS_INC:    next_pc = pc_plus4;
      PS_REG:    next_pc = word_align(pc_in);
      PS_BRANCH: next_pc = pc_plus4 + branch_off;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC stage: fetches into the instruction register, then steps the PC from the control word.
module fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          PS,
  input  logic [ADDR_W-1:0]   K,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic                EN_PC,
  fetch_unit_if.master        imem,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   link_data,
  output logic                link_en,
  output logic [CNT_W-1:0]    instr_count
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  next_pc;
  logic [ADDR_W-1:0]  pc_plus4;

  pc_next_logic u_pc_next (
    .pc       (pc_q),
    .ps       (PS),
    .k        (K),
    .pc_in    (pc_in),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state plus PC/IR/counter updates; memory ready only counts while a request is out.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (req_q && imem.ready) begin
          ir_d    = imem.rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (PS != PS_HOLD) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == EXEC);
  end

  // Datapath and registered handshake flags; req stays low through reset and its first release cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = pc_q;
  assign instruction = ir_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign link_data   = pc_plus4;
  assign link_en     = EN_PC & valid_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction streams vs. a PC model.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  PS = 2'b00;
  logic [63:0] K = '0;
  logic [63:0] pc_in = '0;
  logic        EN_PC = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic [63:0] link_data;
  logic        link_en;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] m_pc  = RST_PC;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_ir  = '0;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .PS          (PS),
    .K           (K),
    .pc_in       (pc_in),
    .EN_PC       (EN_PC),
    .imem        (imem),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .link_data   (link_data),
    .link_en     (link_en),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Serve one fetch with the given number of wait states; leaves the DUT in EXEC.
  task automatic do_fetch(input logic [31:0] d, input int waits);
    int n = 0;
    imem.ready = 1'b0;
    while (imem.req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (imem.req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_timeout req=%b expected 1", imem.req);
    end
    checks++;
    if (imem.addr !== m_pc || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_addr addr=%h valid=%b expected addr=%h valid=0", imem.addr, instr_valid, m_pc);
    end
    for (int i = 0; i < waits; i++) begin
      PS = 2'($urandom); K = rand64(); pc_in = rand64(); EN_PC = 1'($urandom);
      step();
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== m_pc || instr_valid !== 1'b0 ||
          instruction !== m_ir || link_en !== 1'b0) begin
        errors++;
        $display("FAIL wait_state req=%b addr=%h valid=%b ir=%h link_en=%b expected req=1 addr=%h valid=0 ir=%h link_en=0",
                 imem.req, imem.addr, instr_valid, instruction, link_en, m_pc, m_ir);
      end
    end
    imem.ready = 1'b1;
    imem.rdata = d;
    step();
    imem.ready = 1'b0;
    imem.rdata = $urandom;
    m_ir = d;
    checks++;
    if (instr_valid !== 1'b1 || instruction !== d || pc !== m_pc || imem.req !== 1'b0 || instr_count !== m_cnt) begin
      errors++;
      $display("FAIL ir_load valid=%b ir=%h pc=%h req=%b cnt=%0d expected valid=1 ir=%h pc=%h req=0 cnt=%0d",
               instr_valid, instruction, pc, imem.req, instr_count, d, m_pc, m_cnt);
    end
  endtask

  // Apply one control word in EXEC and check the resulting PC/state against the model.
  task automatic do_exec(input logic [1:0] ps, input logic [63:0] k, input logic [63:0] pin, input logic en);
    PS = ps; K = k; pc_in = pin; EN_PC = en;
    #1;
    checks++;
    if (link_en !== en || link_data !== m_pc + 64'd4 || imem.req !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL exec_outputs link_en=%b link_data=%h req=%b valid=%b expected link_en=%b link_data=%h req=0 valid=1",
               link_en, link_data, imem.req, instr_valid, en, m_pc + 64'd4);
    end
    step();
    case (ps)
      2'd1: m_pc = m_pc + 64'd4;
      2'd2: m_pc = (pin / 64'd4) * 64'd4;
      2'd3: m_pc = m_pc + 64'd4 + k * 64'd4;
      default: ;
    endcase
    if (ps != 2'd0) m_cnt = m_cnt + 32'd1;
    checks++;
    if (ps == 2'd0) begin
      if (instr_valid !== 1'b1 || instruction !== m_ir || pc !== m_pc || instr_count !== m_cnt || imem.req !== 1'b0) begin
        errors++;
        $display("FAIL exec_hold valid=%b ir=%h pc=%h cnt=%0d req=%b expected valid=1 ir=%h pc=%h cnt=%0d req=0",
                 instr_valid, instruction, pc, instr_count, imem.req, m_ir, m_pc, m_cnt);
      end
    end else begin
      if (instr_valid !== 1'b0 || pc !== m_pc || instr_count !== m_cnt || imem.req !== 1'b1) begin
        errors++;
        $display("FAIL exec_retire ps=%0d valid=%b pc=%h cnt=%0d req=%b expected valid=0 pc=%h cnt=%0d req=1",
                 ps, instr_valid, pc, instr_count, imem.req, m_pc, m_cnt);
      end
    end
    EN_PC = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; EN_PC = 1'b1; PS = 2'b01; imem.ready = 1'b1; imem.rdata = 32'hDEADBEEF;
    step();
    step();
    checks++;
    if (imem.req !== 1'b0 || instr_valid !== 1'b0 || link_en !== 1'b0 || pc !== RST_PC ||
        instruction !== 32'h0 || instr_count !== 32'h0 || link_data !== RST_PC + 64'd4) begin
      errors++;
      $display("FAIL reset_state req=%b valid=%b link_en=%b pc=%h ir=%h cnt=%0d link=%h expected 0 0 0 %h 0 0 %h",
               imem.req, instr_valid, link_en, pc, instruction, instr_count, link_data, RST_PC, RST_PC + 64'd4);
    end
    imem.ready = 1'b0; EN_PC = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== RST_PC || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
               imem.req, imem.addr, instr_valid, RST_PC);
    end
  endtask

  task automatic test_sequential();
    int c0 = cyc;
    do_fetch(32'hAAAA0001, 0); do_exec(2'b01, '0, '0, 1'b0);
    do_fetch(32'hBBBB0002, 0); do_exec(2'b01, '0, '0, 1'b0);
    do_fetch(32'hCCCC0003, 0); do_exec(2'b01, '0, '0, 1'b0);
    checks++;
    if (instr_count !== 32'd3 || cyc - c0 != 6 || pc !== 64'h0C) begin
      errors++;
      $display("FAIL sequential cnt=%0d cycles=%0d pc=%h expected cnt=3 cycles=6 pc=c", instr_count, cyc - c0, pc);
    end
  endtask

  task automatic test_wait_state();
    do_fetch(32'h11110004, 0); do_exec(2'b01, '0, '0, 1'b0);
    do_fetch(32'h22220005, 3);
    checks++;
    if (pc !== 64'h10) begin
      errors++;
      $display("FAIL wait_pc pc=%h expected 10", pc);
    end
  endtask

  task automatic test_branch();
    do_exec(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, rand64(), 1'b0);
    checks++;
    if (imem.addr !== 64'h0C) begin
      errors++;
      $display("FAIL branch_back addr=%h expected c", imem.addr);
    end
    do_fetch(32'h33330006, 1);
    do_exec(2'b10, rand64(), 64'h1003, 1'b0);
    checks++;
    if (imem.addr !== 64'h1000) begin
      errors++;
      $display("FAIL br_reg addr=%h expected 1000", imem.addr);
    end
  endtask

  task automatic test_bl();
    int c0;
    do_fetch(32'h44440007, 0);
    do_exec(2'b10, '0, 64'h40, 1'b0);
    do_fetch(32'h94000004, 0);
    c0 = cyc;
    do_exec(2'b00, rand64(), rand64(), 1'b1);
    do_exec(2'b11, 64'd4, rand64(), 1'b0);
    checks++;
    if (imem.addr !== 64'h54 || cyc - c0 != 2 || instr_count !== m_cnt) begin
      errors++;
      $display("FAIL bl addr=%h cycles=%0d cnt=%0d expected addr=54 cycles=2 cnt=%0d", imem.addr, cyc - c0, instr_count, m_cnt);
    end
  endtask

  task automatic test_wrap();
    do_fetch(32'h55550008, 0);
    do_exec(2'b10, '0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    do_fetch(32'h66660009, 0);
    do_exec(2'b01, rand64(), rand64(), 1'b0);
    checks++;
    if (imem.addr !== 64'h0) begin
      errors++;
      $display("FAIL pc_wrap addr=%h expected 0", imem.addr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int holds;
      do_fetch($urandom, int'($urandom_range(0, 3)));
      holds = int'($urandom_range(0, 2));
      for (int h = 0; h < holds; h++) do_exec(2'b00, rand64(), rand64(), 1'($urandom));
      do_exec(2'($urandom_range(1, 3)), rand64(), rand64(), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_fetch();
    imem.ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    m_pc = RST_PC; m_cnt = '0; m_ir = '0;
    checks++;
    if (imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== RST_PC || instr_count !== 32'h0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_fetch req=%b valid=%b pc=%h cnt=%0d ir=%h expected req=0 valid=0 pc=%h cnt=0 ir=0",
               imem.req, instr_valid, pc, instr_count, instruction, RST_PC);
    end
    step();
    reset = 1'b1;
    do_fetch(32'h7777000A, 1);
    do_exec(2'b01, '0, '0, 1'b0);
  endtask

  initial begin
    imem.ready = 1'b0;
    imem.rdata = '0;
    test_reset();
    test_sequential();
    test_wait_state();
    test_branch();
    test_bl();
    test_wrap();
    test_random();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
